// File: rtl/dot_arena_engine.sv
// dot_arena_engine: N player dots on a SIZE x SIZE wrap-around grid with a
// writable wall map. Applies keypad move commands, kills players on wall or
// player collisions, and drives a row-scanned red/green LED matrix.
module dot_arena_engine #(
  parameter  int N_PLAYERS = 2,
  parameter  int SIZE      = 8,
  localparam int PW        = $clog2(SIZE),
  localparam int IW        = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic                      scan_en,
  input  logic                      restart,
  input  logic                      key_valid,
  input  logic [IW-1:0]             key_player,
  input  logic [1:0]                key_dir,
  input  logic                      map_we,
  input  logic [PW-1:0]             map_waddr,
  input  logic [SIZE-1:0]           map_wdata,
  output logic [SIZE-1:0]           row,
  output logic [SIZE-1:0]           green,
  output logic [N_PLAYERS*SIZE-1:0] red,
  output logic [N_PLAYERS-1:0]      alive,
  output logic [N_PLAYERS*2*PW-1:0] pos,
  output logic                      hit,
  output logic [IW-1:0]             hit_player,
  output logic                      game_over
);

  typedef enum logic {ALIVE = 1'b0, DEAD = 1'b1} life_t;

  life_t         life_q [N_PLAYERS];
  logic [PW-1:0] x_q    [N_PLAYERS];
  logic [PW-1:0] y_q    [N_PLAYERS];
  logic [SIZE-1:0] wall_q [SIZE];
  logic [PW-1:0] scan_idx;
  logic          hit_q;
  logic [IW-1:0] hit_player_q;

  logic          key_ok;
  logic [PW-1:0] cur_x, cur_y, tx, ty;
  logic          blocked;

  // Decode the command: selected player's position, wrapped target, collision.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    key_ok  = 1'b0;
    cur_x   = '0;
    cur_y   = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (key_player == IW'(i)) begin
        key_ok = (life_q[i] == ALIVE);
        cur_x  = x_q[i];
        cur_y  = y_q[i];
      end
    end
    // Out-of-range indices match no player and leave key_ok low.
    key_ok = key_ok & key_valid;
    tx = cur_x;
    ty = cur_y;
    // PW-bit arithmetic wraps modulo SIZE because SIZE is a power of two.
    case (key_dir)
      2'b00:   tx = cur_x - 1'b1;
      2'b01:   tx = cur_x + 1'b1;
      2'b10:   ty = cur_y - 1'b1;
      default: ty = cur_y + 1'b1;
    endcase
    // Map reads here see the pre-write contents when map_we coincides.
    blocked = wall_q[ty][tx];
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (key_player != IW'(i) && life_q[i] == ALIVE && x_q[i] == tx && y_q[i] == ty)
        blocked = 1'b1;
    end
  end

  // Player state machine: positions, ALIVE/DEAD flags and the hit pulse.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        x_q[i]    <= PW'(i);
        y_q[i]    <= '0;
        life_q[i] <= ALIVE;
      end
      hit_q        <= 1'b0;
      hit_player_q <= '0;
    end else begin
      hit_q <= 1'b0;
      if (restart) begin
        for (int i = 0; i < N_PLAYERS; i++) begin
          x_q[i]    <= PW'(i);
          y_q[i]    <= '0;
          life_q[i] <= ALIVE;
        end
      end else if (key_ok) begin
        for (int i = 0; i < N_PLAYERS; i++) begin
          if (key_player == IW'(i)) begin
            x_q[i] <= tx;
            y_q[i] <= ty;
            if (blocked) life_q[i] <= DEAD;
          end
        end
        if (blocked) begin
          hit_q        <= 1'b1;
          hit_player_q <= key_player;
        end
      end
    end
  end

  // Wall map: row writes; cleared by reset, untouched by restart.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      // NOTE: the map lives in flops (not RAM) so it can be cleared on reset.
      for (int r = 0; r < SIZE; r++) wall_q[r] <= '0;
    end else if (map_we) begin
      wall_q[map_waddr] <= map_wdata;
    end
  end

  // Scan row counter, wrapping naturally at SIZE.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)        scan_idx <= '0;
    else if (scan_en) scan_idx <= scan_idx + 1'b1;
  end

  // Display and status outputs, derived from registered state only.
  always_comb begin
    for (int i = 0; i < N_PLAYERS; i++) begin
      alive[i] = (life_q[i] == ALIVE);
      pos[i*2*PW +: 2*PW] = {y_q[i], x_q[i]};
      red[i*SIZE +: SIZE] = (alive[i] && y_q[i] == scan_idx) ? (SIZE'(1) << x_q[i]) : '0;
    end
    if (N_PLAYERS >= 2) game_over = ($countones(alive) < 2);
    else                game_over = ($countones(alive) == 0);
    row   = {1'b1, {(SIZE-1){1'b0}}} >> scan_idx;
    green = game_over ? '1 : wall_q[scan_idx];
  end

  assign hit        = hit_q;
  assign hit_player = hit_player_q;

endmodule

// File: tb/tb_dot_arena_engine.sv
// Directed bench for dot_arena_engine (SIZE=8, N=2 main instance plus an
// N=3 instance for out-of-range player indices). Expected values are pushed
// to a scoreboard queue with each step and popped when outputs are sampled.
module tb_dot_arena_engine;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        scan_en, restart, key_valid, map_we;
  logic [0:0]  key_player;
  logic [1:0]  key_dir;
  logic [2:0]  map_waddr;
  logic [7:0]  map_wdata;
  logic [7:0]  row, green;
  logic [15:0] red;
  logic [1:0]  alive;
  logic [11:0] pos;
  logic        hit;
  logic [0:0]  hit_player;
  logic        game_over;

  logic        k3_valid;
  logic [1:0]  k3_player, k3_dir;
  logic [7:0]  row3, green3;
  logic [23:0] red3;
  logic [2:0]  alive3;
  logic [17:0] pos3;
  logic        hit3, game_over3;
  logic [1:0]  hit_player3;

  dot_arena_engine #(.N_PLAYERS(2), .SIZE(8)) u_dut (
    .clk_in(clk_in), .reset(reset), .scan_en(scan_en), .restart(restart),
    .key_valid(key_valid), .key_player(key_player), .key_dir(key_dir),
    .map_we(map_we), .map_waddr(map_waddr), .map_wdata(map_wdata),
    .row(row), .green(green), .red(red), .alive(alive), .pos(pos),
    .hit(hit), .hit_player(hit_player), .game_over(game_over)
  );

  dot_arena_engine #(.N_PLAYERS(3), .SIZE(8)) u_dut3 (
    .clk_in(clk_in), .reset(reset), .scan_en(1'b0), .restart(1'b0),
    .key_valid(k3_valid), .key_player(k3_player), .key_dir(k3_dir),
    .map_we(1'b0), .map_waddr(3'd0), .map_wdata(8'd0),
    .row(row3), .green(green3), .red(red3), .alive(alive3), .pos(pos3),
    .hit(hit3), .hit_player(hit_player3), .game_over(game_over3)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %0h expected queued entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) passed++;
      else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask

  // One clock: inputs already set; sample 1 time unit after the edge, clear strobes.
  task automatic cycle();
    @(posedge clk_in);
    #1;
    scan_en = 1'b0; restart = 1'b0; key_valid = 1'b0; map_we = 1'b0; k3_valid = 1'b0;
  endtask

  task automatic move(input logic [0:0] p, input logic [1:0] d);
    key_valid = 1'b1; key_player = p; key_dir = d;
  endtask

  initial begin
    reset = 1'b1; scan_en = 0; restart = 0; key_valid = 0; key_player = 0; key_dir = 0;
    map_we = 0; map_waddr = 0; map_wdata = 0; k3_valid = 0; k3_player = 0; k3_dir = 0;
    repeat (2) @(posedge clk_in);
    #1 reset = 1'b0;

    // Reset state
    push("rst_row", 32'h80); push("rst_pos", 32'h040); push("rst_alive", 32'h3);
    push("rst_red", 32'h0201); push("rst_green", 32'h0); push("rst_over", 32'h0); push("rst_hit", 32'h0);
    chk(row); chk(pos); chk(alive); chk(red); chk(green); chk(game_over); chk(hit);

    // Wrap left x=0 -> 7, then up y=0 -> 7
    move(0, 2'b00); push("wrap_left_pos", 32'h047); push("wrap_left_red", 32'h0280); push("wrap_left_hit", 0);
    cycle(); chk(pos); chk(red); chk(hit);
    move(0, 2'b10); push("wrap_up_pos", 32'h07F); push("wrap_up_red", 32'h0200); push("wrap_up_hit", 0);
    cycle(); chk(pos); chk(red); chk(hit);

    // Scan: 8 pulses walk the one-hot row and return; red follows scan row
    for (int k = 1; k <= 8; k++) begin
      scan_en = 1'b1;
      push("scan_row", 32'h80 >> (k % 8));
      push("scan_red", (k == 7) ? 32'h0080 : ((k == 8) ? 32'h0200 : 32'h0));
      cycle(); chk(row); chk(red);
    end
    push("scan_hold_row", 32'h80);
    cycle(); cycle(); chk(row);

    // Restart; move down; then restart together with a move (move dropped)
    restart = 1'b1; push("restart_pos", 32'h040); push("restart_alive", 32'h3);
    cycle(); chk(pos); chk(alive);
    move(0, 2'b11); push("down_pos", 32'h048);
    cycle(); chk(pos);
    restart = 1'b1; move(0, 2'b10); push("restart_key_pos", 32'h040); push("restart_key_hit", 0);
    cycle(); chk(pos); chk(hit);

    // Wall collision: wall at row 0 col 2, player1 moves right into it
    map_we = 1'b1; map_waddr = 3'd0; map_wdata = 8'h04; push("wall_green", 32'h04);
    cycle(); chk(green);
    move(1, 2'b01);
    push("wall_alive", 32'h1); push("wall_hit", 1); push("wall_hitp", 1);
    push("wall_over", 1); push("wall_green_ff", 32'hFF); push("wall_pos", 32'h080);
    cycle(); chk(alive); chk(hit); chk(hit_player); chk(game_over); chk(green); chk(pos);
    push("wall_hit_pulse", 0); push("wall_still_dead", 32'h1);
    cycle(); chk(hit); chk(alive);

    // Restart keeps the map; then clear it and collide player0 into player1
    restart = 1'b1; push("rs_alive", 32'h3); push("rs_green_map", 32'h04); push("rs_over", 0);
    cycle(); chk(alive); chk(green); chk(game_over);
    map_we = 1'b1; map_waddr = 3'd0; map_wdata = 8'h00;
    cycle();
    move(0, 2'b01);
    push("pp_alive", 32'h2); push("pp_hit", 1); push("pp_hitp", 0); push("pp_pos", 32'h041);
    cycle(); chk(alive); chk(hit); chk(hit_player); chk(pos);
    move(0, 2'b01); push("dead_pos", 32'h041); push("dead_hit", 0); push("dead_alive", 32'h2);
    cycle(); chk(pos); chk(hit); chk(alive);

    // Move in the same cycle as a wall write uses the old map; back-to-back moves
    restart = 1'b1;
    cycle();
    move(1, 2'b11); push("b2b_p1_pos", 32'h240);
    cycle(); chk(pos);
    move(0, 2'b01); map_we = 1'b1; map_waddr = 3'd0; map_wdata = 8'h02;
    push("same_we_hit", 0); push("same_we_alive", 32'h3); push("same_we_pos", 32'h241);
    cycle(); chk(hit); chk(alive); chk(pos);
    move(0, 2'b00); push("back_left_pos", 32'h240); push("back_left_hit", 0);
    cycle(); chk(pos); chk(hit);
    move(0, 2'b01); push("late_hit", 1); push("late_hitp", 0); push("late_alive", 32'h2); push("late_pos", 32'h241);
    cycle(); chk(hit); chk(hit_player); chk(alive); chk(pos);

    // Asynchronous reset mid-cycle while hit is high
    #3 reset = 1'b1;
    #1;
    push("areset_hit", 0); push("areset_pos", 32'h040); push("areset_alive", 32'h3); push("areset_green", 0);
    chk(hit); chk(pos); chk(alive); chk(green);
    #1 reset = 1'b0;

    // N=3 instance: index 3 is out of range and ignored; index 2 moves
    @(posedge clk_in); #1;
    k3_valid = 1'b1; k3_player = 2'd3; k3_dir = 2'b01;
    push("oor_pos", 32'h2040); push("oor_alive", 32'h7); push("oor_hit", 0);
    cycle(); chk(pos3); chk(alive3); chk(hit3);
    k3_valid = 1'b1; k3_player = 2'd2; k3_dir = 2'b01;
    push("p2_pos", 32'h3040);
    cycle(); chk(pos3);

    if (sb.size() != 0) begin
      checks++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dot_arena_engine.md
# dot_arena_engine

Parametrised successor to the two-player LED-matrix dot game core. It holds N player dots on a SIZE×SIZE grid with a writable wall map, and applies four-direction move commands with wrap-around. It detects wall and player-player collisions per player, then produces row-scanned red/green drive for the LED matrix. It sits between the keypad decode/debounce path (which supplies move commands) and the matrix pins.

## Interface
- N_PLAYERS, 2, number of player dots (1..SIZE)
- SIZE, 8, grid edge length (power of two, ≥4); PW = log2(SIZE), IW = max(1, log2(N_PLAYERS))
- clk_in  in  1  system clock
- reset  in  1  asynchronous, active-high
- scan_en  in  1  advances the scan row by one on a clk_in edge when high
- restart  in  1  synchronous game restart; map contents are untouched
- key_valid  in  1  single-cycle move command strobe
- key_player  in  IW  player index for the command
- key_dir  in  2  direction: 00 left (x-1), 01 right (x+1), 10 up (y-1), 11 down (y+1)
- map_we  in  1  wall-map row write enable
- map_waddr  in  PW  wall row to write
- map_wdata  in  SIZE  wall bits for that row; bit x = column x
- row  out  SIZE  one-hot scan row; bit (SIZE-1-scan_idx) set
- green  out  SIZE  wall bits of the current scan row
- red  out  N_PLAYERS*SIZE  field i holds player i's column bit for the current row
- alive  out  N_PLAYERS  per-player alive flag
- pos  out  N_PLAYERS*2*PW  field i = {y_i, x_i}
- hit  out  1  one-cycle collision pulse
- hit_player  out  IW  player that collided; valid while hit=1
- game_over  out  1  set when fewer than 2 players are alive (N_PLAYERS≥2), or when no player is alive (N_PLAYERS=1)

## Operation
- Per-player state: x, y (PW bits each) and an ALIVE/DEAD flag. The flag is a 2-state FSM: ALIVE goes to DEAD on a collision. Only restart or reset returns a player to ALIVE.
- Reset / restart state:
  - Player i at x=i, y=0, ALIVE.
  - scan_idx=0, hit=0.
  - reset additionally clears the whole wall map to 0. restart leaves the map and scan_idx unchanged.
- Move command: accepted only when key_valid=1, key_player<N_PLAYERS and that player is ALIVE. All other commands are ignored with no state change.
- Target cell: the moved coordinate is computed modulo SIZE, so x=SIZE-1 moving right goes to 0, and y=0 moving up goes to SIZE-1.
- Collision: the move collides if the target's wall bit is 1, or if any other ALIVE player occupies the target.
  - On collision the player moves to the target, becomes DEAD, hit=1 and hit_player=index.
  - Otherwise the player simply moves.
  - DEAD players are not obstacles.
- Collisions are evaluated only on moves. A map write onto an occupied cell does not kill that player.
- Display (combinational from registered state):
  - red field i has bit x_i set only when y_i==scan_idx and player i is ALIVE; otherwise it is zero.
  - green = wall row scan_idx; it is forced to all ones while game_over=1.
- scan_idx increments on scan_en and wraps SIZE-1 to 0.

## Timing
- Every state update occurs on a rising clk_in edge. The new position, alive flag, hit and game_over are all visible in the cycle after the key_valid edge (1-cycle latency).
- hit is high for exactly one cycle per colliding command.
- Priority: reset > restart > move.
  - If restart and key_valid are asserted together, restart wins and the move is dropped.
- A move in the same cycle as map_we uses the pre-write map contents. The write takes effect after the edge.
- Only one command is accepted per cycle. Back-to-back key_valid pulses on consecutive cycles are all processed, each against the updated state.
- reset asserted mid-operation clears everything immediately (asynchronously), including a pending hit.

## Test plan
- Reset with SIZE=8, N=2: row=8'b1000_0000, pos0={0,0}, pos1={0,1}, alive=2'b11, red field0=8'b0000_0001, field1=8'b0000_0010, green=0, game_over=0.
- Wrap-around: player0 left from x=0 → x=7. Then up from y=0 → y=7; red field0 goes nonzero only when scan_idx=7. No hit.
- Wall collision: write map row 0 = 8'b0000_0100, then move player1 right (1→2). Next cycle: alive[1]=0, hit=1 for one cycle, hit_player=1, game_over=1, green=8'hFF.
- Player collision and dead-player rules:
  - Move player0 right onto player1 at (1,0) → player0 DEAD, player1 stays ALIVE.
  - Commands to dead player0 and to key_player=3 are ignored.
- Simultaneous events:
  - restart together with key_valid → positions back to reset values, move dropped.
  - map_we to row 0 col 1 together with a move of player0 onto col 1 → no hit. A later move onto col 1 → hit.
- Scan: 8 scan_en pulses cycle row through all one-hot values and back to 8'b1000_0000. With scan_en=0, row holds its value.
